instr_decode_pipe: RTL and testbench
====================================

# instr_decode_pipe

Parametrised, two-stage pipelined instruction decoder for the APCPU core, replacing the single-register decoder. It sits between instruction fetch and the ALU/register-file select logic. It accepts instruction words over a valid/ready handshake and splits each word into ALU opcode, register selects and data/immediate field. It adds an immediate/register format bit, illegal-opcode detection, flush, backpressure and decode/illegal counters.

## Interface
- INSTR_W, 32, instruction width
- OPC_W, 8, opcode field width (instr[INSTR_W-1 -: OPC_W])
- REG_SEL_W, 3, width of each register select
- AP_W, 3, address-pointer select width
- NUM_OPS, 96, number of legal op indices
- CNT_W, 16, counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  instruction present
- in_ready  out  1  decoder can accept this cycle
- instr  in  INSTR_W  instruction word
- ap_sel  in  AP_W  address-pointer select, carried with instr
- out_valid  out  1  decoded result present
- out_ready  in  1  consumer accepts result
- alu_code  out  OPC_W  decoded opcode (0 when illegal)
- dec_data  out  DATA_W=INSTR_W-OPC_W  data/immediate field
- reg_sel_x / reg_sel_y / reg_sel_z  out  REG_SEL_W  register selects
- out_ap_sel  out  AP_W  ap_sel of this instruction
- is_imm  out  1  immediate format
- illegal  out  1  op index >= NUM_OPS
- decode_cnt  out  CNT_W  completed output handshakes
- illegal_cnt  out  CNT_W  illegal instructions emitted

## Operation
- Opcode op = instr[INSTR_W-1 -: OPC_W]. Format bit f = op[OPC_W-1]. Index idx = op[OPC_W-2:0].
- X = instr[DATA_W-1 -: REG_SEL_W]. Y is the next REG_SEL_W bits below X. Z is the next REG_SEL_W bits below Y.
- Immediate (f=1): dec_data = instr[DATA_W-1:0]; reg_sel_x = X; reg_sel_y = reg_sel_z = 0; is_imm = 1.
- Register (f=0): reg_sel_x/y/z = X/Y/Z; dec_data = remaining low DATA_W-3*REG_SEL_W bits, zero-extended; is_imm = 0.
- Illegal when idx >= NUM_OPS:
  - illegal = 1, alu_code = 0 (NOP).
  - Other fields are still decoded.
- Stage 1 registers instr and ap_sel. Stage 2 registers all decoded fields.
- Stage 2 loads when it is empty or out_ready = 1.
- in_ready = !flush && (!s1_valid || s2 loads) (combinational).
- Outputs hold stable while out_valid && !out_ready.
- decode_cnt increments on each out_valid && out_ready and wraps at 2^CNT_W.
- illegal_cnt increments on each handshake with illegal = 1 and saturates at all-ones.
- flush clears s1_valid and s2_valid next edge and forces in_ready = 0. Flushed instructions are never counted. Counters are not cleared by flush.

## Timing
- Latency: accepted at edge N means out_valid at edge N+2 with no stall. Throughput is 1 per cycle.
- Reset (rst_n=0, asynchronous): all stage registers, out_valid, alu_code, dec_data, reg selects, out_ap_sel, is_imm, illegal and both counters = 0. in_ready = 1 when flush = 0.
- Full pipeline with out_ready = 0: in_ready = 0, no word is lost or duplicated.
- out_ready rising with both stages full: stage 2 takes stage 1 and stage 1 takes a new input in the same cycle.
- flush concurrent with in_valid: input not accepted. flush concurrent with output handshake: handshake counts, because out_valid was already high.
- rst_n assertion mid-stream discards everything immediately. First accept is on the first edge after release.

## Test plan
- Immediate: instr=0xC464AD48, ap_sel=5, out_ready=1 -> two cycles later alu_code=0xC4, is_imm=1, dec_data=0x64AD48, X=3, Y=0, Z=0, out_ap_sel=5, illegal=0.
- Register: instr=0x4464AD48 -> alu_code=0x44, is_imm=0, X=3, Y=1, Z=1, dec_data=0x002D48.
- Illegal: instr=0x7F000000 -> illegal=1, alu_code=0, illegal_cnt=1, decode_cnt=1.
- Backpressure:
  - Stimulus: stream 8 words with out_ready=0 for 5 cycles, then 1.
  - Required: in_ready drops after 2 accepts, held outputs stay stable, all 8 words emerge in order, decode_cnt=8.
- Flush: 2 words in flight, then flush=1 for one cycle -> out_valid=0 next cycle, decode_cnt unchanged, next word emerges 2 cycles after acceptance.
- Reset mid-stream and wrap:
  - Async rst_n pulse between edges -> all outputs 0 immediately.
  - With CNT_W=4, 17 handshakes -> decode_cnt=1.
  - With CNT_W=4, 17 illegal handshakes -> illegal_cnt=15.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// Two-stage pipelined instruction decoder: stage 1 captures the raw word, stage 2 holds the
// decoded fields. Valid/ready handshake on both sides, with flush and handshake counters.
module instr_decode_pipe #(
  parameter int INSTR_W   = 32,
  parameter int OPC_W     = 8,
  parameter int REG_SEL_W = 3,
  parameter int AP_W      = 3,
  parameter int NUM_OPS   = 96,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr,
  input  logic [AP_W-1:0]            ap_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPC_W-1:0]           alu_code,
  output logic [INSTR_W-OPC_W-1:0]   dec_data,
  output logic [REG_SEL_W-1:0]       reg_sel_x,
  output logic [REG_SEL_W-1:0]       reg_sel_y,
  output logic [REG_SEL_W-1:0]       reg_sel_z,
  output logic [AP_W-1:0]            out_ap_sel,
  output logic                       is_imm,
  output logic                       illegal,
  output logic [CNT_W-1:0]           decode_cnt,
  output logic [CNT_W-1:0]           illegal_cnt
);
  localparam int DATA_W = INSTR_W - OPC_W;
  localparam int LOW_W  = DATA_W - 3 * REG_SEL_W;
  localparam logic [OPC_W-1:0] NUM_OPS_V = OPC_W'(NUM_OPS);

  logic                 s1_valid;
  logic [INSTR_W-1:0]   s1_instr;
  logic [AP_W-1:0]      s1_ap;

  logic                 s2_load;
  logic                 accept;
  logic                 handshake;

  logic [OPC_W-1:0]     op;
  logic                 fmt;
  logic [OPC_W-2:0]     idx;
  logic [REG_SEL_W-1:0] d_x;
  logic [REG_SEL_W-1:0] d_y;
  logic [REG_SEL_W-1:0] d_z;
  logic [DATA_W-1:0]    d_data;
  logic                 d_ill;
  logic [OPC_W-1:0]     d_alu;

  assign s2_load   = !out_valid || out_ready;
  assign in_ready  = !flush && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  assign op  = s1_instr[INSTR_W-1 -: OPC_W];
  assign fmt = op[OPC_W-1];
  assign idx = op[OPC_W-2:0];

  always_comb begin
    d_x    = s1_instr[DATA_W-1 -: REG_SEL_W];
    d_y    = '0;
    d_z    = '0;
    d_data = '0;
    d_ill  = ({1'b0, idx} >= NUM_OPS_V);
    d_alu  = d_ill ? '0 : op;
    if (fmt) begin
      d_data = s1_instr[DATA_W-1:0];
    end else begin
      d_y    = s1_instr[DATA_W-1-REG_SEL_W -: REG_SEL_W];
      d_z    = s1_instr[DATA_W-1-2*REG_SEL_W -: REG_SEL_W];
      d_data = {{(3*REG_SEL_W){1'b0}}, s1_instr[LOW_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_instr    <= '0;
      s1_ap       <= '0;
      out_valid   <= 1'b0;
      alu_code    <= '0;
      dec_data    <= '0;
      reg_sel_x   <= '0;
      reg_sel_y   <= '0;
      reg_sel_z   <= '0;
      out_ap_sel  <= '0;
      is_imm      <= 1'b0;
      illegal     <= 1'b0;
      decode_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      // A handshake in the flush cycle still counts: out_valid was already high.
      if (handshake) begin
        decode_cnt <= decode_cnt + 1'b1;
        if (illegal && !(&illegal_cnt))
          illegal_cnt <= illegal_cnt + 1'b1;
      end

      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s2_load) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            alu_code   <= d_alu;
            dec_data   <= d_data;
            reg_sel_x  <= d_x;
            reg_sel_y  <= d_y;
            reg_sel_z  <= d_z;
            out_ap_sel <= s1_ap;
            is_imm     <= fmt;
            illegal    <= d_ill;
          end
        end
        if (accept) begin
          s1_valid <= 1'b1;
          s1_instr <= instr;
          s1_ap    <= ap_sel;
        end else if (s2_load) begin
          s1_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Scoreboard bench for instr_decode_pipe: the driver pushes hand-computed expectations on
// accept, a forked monitor pops and compares on every output handshake.
module tb_instr_decode_pipe;
  typedef struct packed {
    logic [7:0]  alu;
    logic [23:0] data;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [2:0]  z;
    logic [2:0]  ap;
    logic        imm;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [2:0]  ap_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  alu_code;
  logic [23:0] dec_data;
  logic [2:0]  reg_sel_x, reg_sel_y, reg_sel_z, out_ap_sel;
  logic        is_imm, illegal;
  logic [3:0]  decode_cnt, illegal_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [3:0] exp_dec = '0;
  logic [3:0] exp_ill = '0;

  instr_decode_pipe #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ap_sel(ap_sel), .out_valid(out_valid), .out_ready(out_ready),
    .alu_code(alu_code), .dec_data(dec_data), .reg_sel_x(reg_sel_x), .reg_sel_y(reg_sel_y),
    .reg_sel_z(reg_sel_z), .out_ap_sel(out_ap_sel), .is_imm(is_imm), .illegal(illegal),
    .decode_cnt(decode_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] alu, input logic [23:0] data,
                              input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                              input logic imm, input logic ill);
    exp_t e;
    e.alu = alu; e.data = data; e.x = x; e.y = y; e.z = z; e.ap = '0; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.alu = alu_code; a.data = dec_data; a.x = reg_sel_x; a.y = reg_sel_y; a.z = reg_sel_z;
    a.ap = out_ap_sel; a.imm = is_imm; a.ill = illegal;
    return a;
  endfunction

  // Inputs change at posedge+1; the monitor samples at negedge, where the next edge's
  // handshakes are already decided.
  task automatic monitor_loop();
    exp_t held;
    exp_t act;
    exp_t e;
    bit   held_v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 0;
        continue;
      end
      act = observed();
      if (out_valid && held_v) chk("held_stable", 64'(act), 64'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("decoded", 64'(act), 64'(e));
          chk("decode_cnt_pre", 64'(decode_cnt), 64'(exp_dec));
          chk("illegal_cnt_pre", 64'(illegal_cnt), 64'(exp_ill));
          exp_dec = exp_dec + 4'd1;
          if (e.ill && exp_ill != 4'hF) exp_ill = exp_ill + 4'd1;
        end
        held_v = 0;
      end else if (out_valid) begin
        held = act;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (flush) q.delete();
    end
  endtask

  task automatic try_cycle(input logic [31:0] w, input logic [2:0] a, input exp_t e,
                           output bit acc);
    exp_t ea;
    instr = w; ap_sel = a; in_valid = 1'b1;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      ea = e;
      ea.ap = a;
      q.push_back(ea);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [2:0] a, input exp_t e);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 100) begin
      try_cycle(w, a, e, acc);
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    exp_dec = '0;
    exp_ill = '0;
    #1;
  endtask

  function automatic exp_t stream_exp(input int k);
    return mk(8'h05, 24'(k), 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_counters", 64'({decode_cnt, illegal_cnt}), 64'd0);
    chk("rst_fields", 64'(observed()), 64'd0);
    rst_n = 1'b1;

    // Directed decode vectors, full throughput
    out_ready = 1'b1;
    send(32'hC464AD48, 3'd5, mk(8'hC4, 24'h64AD48, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0));
    send(32'h4464AD48, 3'd2, mk(8'h44, 24'h002D48, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0));
    send(32'h7F000000, 3'd0, mk(8'h00, 24'h000000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1));
    send(32'h60FFFFFF, 3'd7, mk(8'h00, 24'h007FFF, 3'd7, 3'd7, 3'd7, 1'b0, 1'b1));
    send(32'h5F000001, 3'd1, mk(8'h5F, 24'h000001, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0));
    send(32'hE0ABCDEF, 3'd6, mk(8'h00, 24'hABCDEF, 3'd5, 3'd0, 3'd0, 1'b1, 1'b1));
    drain();
    @(posedge clk);
    #1;
    chk("cnt_after_vectors", 64'(decode_cnt), 64'd6);
    chk("ill_after_vectors", 64'(illegal_cnt), 64'd3);

    // Backpressure: 5 stalled cycles accept only 2 words
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      try_cycle(32'h05000000 | 32'(16 + k), 3'(16 + k), stream_exp(16 + k), acc);
      if (acc) k++;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    while (k < 8) begin
      send(32'h05000000 | 32'(16 + k), 3'(16 + k), stream_exp(16 + k));
      k++;
    end
    drain();
    @(posedge clk);
    #1;
    chk("cnt_after_stream", 64'(decode_cnt), 64'd14);

    // Flush two words in flight while stalled
    out_ready = 1'b0;
    send(32'h05000100, 3'd1, stream_exp(32'h100));
    send(32'h05000101, 3'd2, stream_exp(32'h101));
    flush = 1'b1;
    instr = 32'h05000102; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_cnt", 64'(decode_cnt), 64'd14);
    out_ready = 1'b1;
    send(32'h4464AD48, 3'd7, mk(8'h44, 24'h002D48, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0));
    chk("lat_first_edge", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_second_edge", 64'(out_valid), 64'd1);
    drain();
    @(posedge clk);
    #1;
    chk("cnt_after_flush", 64'(decode_cnt), 64'd15);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    send(32'h05000200, 3'd3, stream_exp(32'h200));
    send(32'h05000201, 3'd4, stream_exp(32'h201));
    #1;
    do_reset();
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_fields", 64'(observed()), 64'd0);
    chk("async_rst_cnts", 64'({decode_cnt, illegal_cnt}), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h05000300, 3'd5, stream_exp(32'h300));
    chk("post_rst_lat1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_lat2", 64'(out_valid), 64'd1);
    drain();

    // Counter wrap and saturation with a 4-bit counter
    @(posedge clk);
    #2;
    do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++)
      send(32'h7F000000, 3'(i), mk(8'h00, 24'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1));
    drain();
    @(posedge clk);
    #1;
    chk("wrap_decode_cnt", 64'(decode_cnt), 64'd1);
    chk("sat_illegal_cnt", 64'(illegal_cnt), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
